// File: rtl/axi_dma_wr_burst_pkg.sv
// Shared AXI field widths, response/burst codes and FSM encoding for the
// burst-splitting write DMA.
package axi_dma_wr_burst_pkg;

  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 1;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam int                 PAGE_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Byte-offset bits of one data beat, i.e. the AXI awsize encoding.
  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_dma_wr_burst_if.sv
// AXI4 write-only bus (AW, W, B) between the DMA master and the MIG slave.
// Every channel is valid/ready: a beat transfers on a clock edge where both are
// high, and a raised valid holds its payload stable until that edge.
interface axi_dma_wr_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  import axi_dma_wr_burst_pkg::*;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [SIZE_W-1:0]   awsize;
  logic [BURST_W-1:0]  awburst;
  logic [LOCK_W-1:0]   awlock;
  logic [CACHE_W-1:0]  awcache;
  logic [PROT_W-1:0]   awprot;
  logic [QOS_W-1:0]    awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [RESP_W-1:0]   bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_dma_wr_burst_calc.sv
// Burst-length calculator: the smallest of the burst cap, the beats still to
// send and the beats left before the next 4 KB page boundary.
module axi_dma_wr_burst_calc
  import axi_dma_wr_burst_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic [11:0]      page_off,
  input  logic [CNT_W-1:0] remaining,
  output logic [8:0]       blen
);
  localparam int SIZE = beat_shift(DATA_W);

  logic [12:0] page_bytes;
  logic [12:0] page_beats;
  logic [31:0] lim;
  logic        unused_lim;

  always_comb begin
    page_bytes = 13'(PAGE_BYTES) - {1'b0, page_off};
    page_beats = page_bytes >> SIZE;
    lim        = 32'(BURST_LEN);
    if (32'(remaining) < lim)  lim = 32'(remaining);
    if (32'(page_beats) < lim) lim = 32'(page_beats);
  end

  assign blen       = lim[8:0];
  assign unused_lim = ^lim[31:9];

endmodule

// File: rtl/axi_dma_wr_burst.sv
// AXI4 write DMA: splits a (start address, beat count) command into INCR bursts
// that never cross a 4 KB page, one burst outstanding at a time.
module axi_dma_wr_burst
  import axi_dma_wr_burst_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16,
  parameter int AXI_ID    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [CNT_W-1:0]    cmd_beats,
  input  logic                valid,
  output logic                ready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                busy,
  output logic                done,
  output logic                error,
  axi_dma_wr_burst_if.master  m_axi,
  output state_t              dbg_state
);
  localparam int SIZE = beat_shift(DATA_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SIZE) - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, awaddr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [8:0]        blen_q, blen_calc;
  logic [7:0]        awlen_q, beat_q;
  logic              cmd_hs, w_hs, last_hs, b_hs, last_burst;
  logic              unused_bid;

  assign cmd_hs     = cmd_valid & cmd_ready;
  assign w_hs       = m_axi.wvalid & m_axi.wready;
  assign last_hs    = w_hs & m_axi.wlast;
  assign b_hs       = m_axi.bvalid & m_axi.bready;
  assign last_burst = (remaining_q == CNT_W'(blen_q));
  assign unused_bid = ^m_axi.bid;
  assign dbg_state  = state;

  axi_dma_wr_burst_calc #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_calc (
    .page_off  (addr_q[11:0]),
    .remaining (remaining_q),
    .blen      (blen_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_hs && cmd_beats != '0) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_ADDR;
      ST_ADDR: if (m_axi.awready) state_nxt = ST_DATA;
      ST_DATA: if (last_hs) state_nxt = ST_RESP;
      ST_RESP: if (b_hs) state_nxt = last_burst ? ST_IDLE : ST_CALC;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // W channel is a straight pass-through of the databus while in DATA.
  always_comb begin
    cmd_ready     = 1'b0;
    ready         = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_ADDR: m_axi.awvalid = 1'b1;
      ST_DATA: begin
        ready        = m_axi.wready;
        m_axi.wvalid = valid;
        m_axi.wlast  = (beat_q == awlen_q);
      end
      ST_RESP: m_axi.bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      awaddr_q    <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_hs) begin
          addr_q      <= cmd_addr & ~ALIGN_MASK;
          remaining_q <= cmd_beats;
          error       <= 1'b0;
          busy        <= (cmd_beats != '0);
          done        <= (cmd_beats == '0);
        end
        ST_CALC: begin
          awaddr_q <= addr_q;
          blen_q   <= blen_calc;
          awlen_q  <= blen_calc[7:0] - 8'd1;
        end
        ST_ADDR: if (m_axi.awready) beat_q <= '0;
        ST_DATA: if (w_hs) beat_q <= beat_q + 8'd1;
        ST_RESP: if (b_hs) begin
          // A bad response is only recorded; the rest of the command still runs.
          if (m_axi.bresp != RESP_OKAY) error <= 1'b1;
          addr_q      <= addr_q + (ADDR_W'(blen_q) << SIZE);
          remaining_q <= remaining_q - CNT_W'(blen_q);
          if (last_burst) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi.awid    = ID_W'(AXI_ID);
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = SIZE_W'(SIZE);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = '0;
  assign m_axi.awcache = 4'h2;
  assign m_axi.awprot  = 3'b010;
  assign m_axi.awqos   = '0;
  assign m_axi.wdata   = wdata;
  assign m_axi.wstrb   = wstrb;

endmodule
